// File: rtl/s10077_line_capture_if.sv
// rtl/s10077_line_capture_if.sv - output pixel stream bundle for the line capture block
//
// Signals:
//   OUT_VALID  beat valid (master -> slave)
//   OUT_READY  beat accepted when OUT_VALID & OUT_READY (slave -> master)
//   OUT_DATA   pixel value, ADC_W bits
//   OUT_LAST   high on the final pixel of a line
//   OUT_LINE   8-bit line id of the beat
interface s10077_line_capture_if #(
    parameter int ADC_W = 12
);
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [ADC_W-1:0] OUT_DATA;
    logic             OUT_LAST;
    logic [7:0]       OUT_LINE;

    modport master (
        output OUT_VALID,
        output OUT_DATA,
        output OUT_LAST,
        output OUT_LINE,
        input  OUT_READY
    );

    modport slave (
        input  OUT_VALID,
        input  OUT_DATA,
        input  OUT_LAST,
        input  OUT_LINE,
        output OUT_READY
    );
endinterface

// File: rtl/s10077_line_capture.sv
// rtl/s10077_line_capture.sv - per-ST sensor line capture into ping-pong buffer with streamed readout
//
// Ports:
//   FPGA_CLK   system clock, rising edge
//   FPGA_RST   asynchronous active-high reset
//   ST         sensor start level; its falling edge arms a capture
//   EOC_EDGE   1-cycle end-of-scan pulse
//   PIX_STB    1-cycle pixel strobe qualifying PIX_DATA
//   PIX_DATA   pixel sample
//   out_bus    output pixel stream (master side)
//   ERR_SHORT  sticky short-line flag
//   ERR_OVR    sticky overrun flag (line dropped, both banks full)
//   DROP_CNT   saturating count of dropped/discarded lines
module s10077_line_capture #(
    parameter  int NPIX   = 1024,
    parameter  int ADC_W  = 12,
    localparam int ADDR_W = $clog2(NPIX)
) (
    input  logic                     FPGA_CLK,
    input  logic                     FPGA_RST,
    input  logic                     ST,
    input  logic                     EOC_EDGE,
    input  logic                     PIX_STB,
    input  logic [ADC_W-1:0]         PIX_DATA,
    s10077_line_capture_if.master    out_bus,
    output logic                     ERR_SHORT,
    output logic                     ERR_OVR,
    output logic [7:0]               DROP_CNT
);

    localparam logic [ADDR_W:0] PIX_LAST = (ADDR_W + 1)'(NPIX - 1);
    localparam logic [ADDR_W:0] PIX_N    = (ADDR_W + 1)'(NPIX);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_WAIT_EOC,
        S_SKIP
    } cap_state_t;

    cap_state_t state, state_nx;

    logic              st_d;
    logic              st_fall;
    logic [ADDR_W:0]   pix_cnt;
    logic              wbank;
    logic              rbank;
    logic [1:0]        full;
    logic [1:0]        full_nx;
    logic [7:0]        line_id;
    logic [7:0]        bank_line [2];

    logic              do_arm;
    logic              do_write;
    logic              do_commit;
    logic              do_short;
    logic              do_ovr;

    logic [ADC_W-1:0]  mem [2][NPIX];

    // Readout pipeline: RAM output stage, then output register plus one skid entry.
    logic [ADDR_W:0]   rd_cnt;
    logic              rd_issue;
    logic              rd_pend;
    logic [ADC_W-1:0]  ram_q;
    logic              ram_last;
    logic [7:0]        ram_line;

    logic              ov;
    logic [ADC_W-1:0]  od;
    logic              ol;
    logic [7:0]        oline;
    logic              sv;
    logic [ADC_W-1:0]  sd;
    logic              sl;
    logic [7:0]        sline;

    logic              pop;
    logic              last_hs;
    logic [1:0]        occ_nx;

    assign st_fall = st_d & ~ST;

    // ---------------------------------------------------------------- capture FSM
    always_ff @(posedge FPGA_CLK or posedge FPGA_RST) begin
        if (FPGA_RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        do_arm    = 1'b0;
        do_write  = 1'b0;
        do_commit = 1'b0;
        do_short  = 1'b0;
        do_ovr    = 1'b0;
        case (state)
            S_IDLE: begin
                if (st_fall) begin
                    if (full[wbank]) begin
                        do_ovr   = 1'b1;
                        state_nx = S_SKIP;
                    end else begin
                        do_arm   = 1'b1;
                        state_nx = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                do_write = PIX_STB;
                // The strobe is consumed before any end-of-line event in the same
                // cycle, so a strobe that completes the line wins over the error.
                if (PIX_STB && (pix_cnt == PIX_LAST)) begin
                    if (EOC_EDGE || st_fall) begin
                        do_commit = 1'b1;
                        state_nx  = S_IDLE;
                    end else begin
                        state_nx  = S_WAIT_EOC;
                    end
                end else if (EOC_EDGE || st_fall) begin
                    do_short = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_WAIT_EOC: begin
                if (EOC_EDGE) begin
                    do_commit = 1'b1;
                    state_nx  = S_IDLE;
                end
            end
            S_SKIP: begin
                if (EOC_EDGE || st_fall) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // A bank freed by the final handshake and a bank filled by a commit are
    // always different banks, so both updates can land in the same cycle.
    always_comb begin
        full_nx = full;
        if (last_hs) begin
            full_nx[rbank] = 1'b0;
        end
        if (do_commit) begin
            full_nx[wbank] = 1'b1;
        end
    end

    always_ff @(posedge FPGA_CLK or posedge FPGA_RST) begin
        if (FPGA_RST) begin
            st_d         <= 1'b0;
            pix_cnt      <= '0;
            wbank        <= 1'b0;
            rbank        <= 1'b0;
            full         <= 2'b00;
            line_id      <= 8'd0;
            bank_line[0] <= 8'd0;
            bank_line[1] <= 8'd0;
            ERR_SHORT    <= 1'b0;
            ERR_OVR      <= 1'b0;
            DROP_CNT     <= 8'd0;
        end else begin
            st_d <= ST;
            full <= full_nx;
            if (do_arm) begin
                pix_cnt <= '0;
            end else if (do_write) begin
                pix_cnt <= pix_cnt + CNT_ONE;
            end
            if (do_commit) begin
                bank_line[wbank] <= line_id;
                wbank            <= ~wbank;
                line_id          <= line_id + 8'd1;
            end
            if (last_hs) begin
                rbank <= ~rbank;
            end
            if (do_short) begin
                ERR_SHORT <= 1'b1;
            end
            if (do_ovr) begin
                ERR_OVR <= 1'b1;
            end
            if ((do_short || do_ovr) && (DROP_CNT != 8'hFF)) begin
                DROP_CNT <= DROP_CNT + 8'd1;
            end
        end
    end

    // ---------------------------------------------------------------- line buffer
    always_ff @(posedge FPGA_CLK) begin
        if (do_write) begin
            mem[wbank][pix_cnt[ADDR_W-1:0]] <= PIX_DATA;
        end
        if (rd_issue) begin
            ram_q <= mem[rbank][rd_cnt[ADDR_W-1:0]];
        end
    end

    // ---------------------------------------------------------------- readout
    assign pop     = ov & out_bus.OUT_READY;
    assign last_hs = pop & ol;

    // Entries held in the output/skid registers after this edge. A read issued
    // now lands one cycle later, so it is only issued when at most one entry
    // will be held; this gives full throughput with no overflow of the skid.
    assign occ_nx   = 2'(ov) + 2'(sv) + 2'(rd_pend) - 2'(pop);
    assign rd_issue = full[rbank] && (rd_cnt != PIX_N) && (occ_nx <= 2'd1);

    always_ff @(posedge FPGA_CLK or posedge FPGA_RST) begin
        if (FPGA_RST) begin
            rd_cnt   <= '0;
            rd_pend  <= 1'b0;
            ram_last <= 1'b0;
            ram_line <= 8'd0;
            ov       <= 1'b0;
            od       <= '0;
            ol       <= 1'b0;
            oline    <= 8'd0;
            sv       <= 1'b0;
            sd       <= '0;
            sl       <= 1'b0;
            sline    <= 8'd0;
        end else begin
            rd_pend <= rd_issue;
            if (rd_issue) begin
                ram_last <= (rd_cnt == PIX_LAST);
                ram_line <= bank_line[rbank];
            end
            if (last_hs) begin
                rd_cnt <= '0;
            end else if (rd_issue) begin
                rd_cnt <= rd_cnt + CNT_ONE;
            end

            if (!ov || pop) begin
                if (sv) begin
                    ov    <= 1'b1;
                    od    <= sd;
                    ol    <= sl;
                    oline <= sline;
                    sv    <= rd_pend;
                    if (rd_pend) begin
                        sd    <= ram_q;
                        sl    <= ram_last;
                        sline <= ram_line;
                    end
                end else if (rd_pend) begin
                    ov    <= 1'b1;
                    od    <= ram_q;
                    ol    <= ram_last;
                    oline <= ram_line;
                end else begin
                    ov <= 1'b0;
                end
            end else if (rd_pend) begin
                sv    <= 1'b1;
                sd    <= ram_q;
                sl    <= ram_last;
                sline <= ram_line;
            end
        end
    end

    assign out_bus.OUT_VALID = ov;
    assign out_bus.OUT_DATA  = od;
    assign out_bus.OUT_LAST  = ol;
    assign out_bus.OUT_LINE  = oline;

endmodule
